// File: rtl/issue_hold_reg.sv
// Dual-issue decode->execute pipeline register with operand forwarding and a one-entry
// hold buffer for a stalled slot B. Optional issue statistics under `ISSUE_STATS_EN`.
module issue_hold_reg #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic [1:0]                   d_valid,
    input  logic [1:0][DATA_W-1:0]       d_pc,
    input  logic [1:0][REG_W-1:0]        d_ra1,
    input  logic [1:0][REG_W-1:0]        d_ra2,
    input  logic [1:0][REG_W-1:0]        d_dst,
    input  logic [1:0][DATA_W-1:0]       d_rd1,
    input  logic [1:0][DATA_W-1:0]       d_rd2,
    input  logic [1:0]                   sel_stall,
    input  logic [1:0][1:0]              sel_a,
    input  logic [1:0][1:0]              sel_b,
    input  logic [DATA_W-1:0]            aluoutE,
    input  logic [DATA_W-1:0]            aluoutM,
    input  logic [DATA_W-1:0]            memdataM,
    output logic                         d_ready,
    output logic                         hold_valid,
    output logic [REG_W-1:0]             hold_ra1,
    output logic [REG_W-1:0]             hold_ra2,
    output logic [REG_W-1:0]             hold_dst,
    output logic [1:0]                   e_valid,
    output logic [1:0][DATA_W-1:0]       e_pc,
    output logic [1:0][REG_W-1:0]        e_dst,
    output logic [1:0][DATA_W-1:0]       e_opa,
    output logic [1:0][DATA_W-1:0]       e_opb
`ifdef ISSUE_STATS_EN
    ,
    output logic [CNT_W-1:0]             stat_bubble,
    output logic [CNT_W-1:0]             stat_split
`endif
);

    typedef enum logic {RUN = 1'b0, HOLD_B = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_hold_pc, r_hold_rd1, r_hold_rd2;
    logic [REG_W-1:0]    r_hold_ra1, r_hold_ra2, r_hold_dst;

    logic [1:0]          w_issue;
    logic                w_d_ready, w_latch_b;
    logic                w_a_valid, w_b_valid, w_stall_a, w_stall_b;
    logic [DATA_W-1:0]   w_a_pc, w_a_rd1, w_a_rd2;
    logic [REG_W-1:0]    w_a_ra1, w_a_ra2, w_a_dst;
    logic [DATA_W-1:0]   w_opa_a, w_opb_a, w_opa_b, w_opb_b;

    function automatic logic [DATA_W-1:0] fwd(
        input logic [1:0]        sel,
        input logic [REG_W-1:0]  ra,
        input logic [DATA_W-1:0] rd
    );
        if (ra == '0) return rd;
        case (sel)
            2'd0:    return rd;
            2'd1:    return aluoutE;
            2'd2:    return aluoutM;
            default: return memdataM;
        endcase
    endfunction

    // In HOLD_B the buffered instruction takes the slot A position and slot A controls.
    assign w_a_valid = (r_state == HOLD_B) ? 1'b1       : d_valid[0];
    assign w_a_pc    = (r_state == HOLD_B) ? r_hold_pc  : d_pc[0];
    assign w_a_ra1   = (r_state == HOLD_B) ? r_hold_ra1 : d_ra1[0];
    assign w_a_ra2   = (r_state == HOLD_B) ? r_hold_ra2 : d_ra2[0];
    assign w_a_dst   = (r_state == HOLD_B) ? r_hold_dst : d_dst[0];
    assign w_a_rd1   = (r_state == HOLD_B) ? r_hold_rd1 : d_rd1[0];
    assign w_a_rd2   = (r_state == HOLD_B) ? r_hold_rd2 : d_rd2[0];

    // Slot B only counts alongside a valid slot A, which keeps program order intact.
    assign w_b_valid = (r_state == RUN) && d_valid[0] && d_valid[1];
    assign w_stall_a = w_a_valid && sel_stall[0];
    assign w_stall_b = w_b_valid && sel_stall[1];

    assign w_opa_a = fwd(sel_a[0], w_a_ra1, w_a_rd1);
    assign w_opb_a = fwd(sel_b[0], w_a_ra2, w_a_rd2);
    assign w_opa_b = fwd(sel_a[1], d_ra1[1], d_rd1[1]);
    assign w_opb_b = fwd(sel_b[1], d_ra2[1], d_rd2[1]);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 2'b00;
        w_d_ready   = 1'b0;
        w_latch_b   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_stall_a) begin
                    w_issue = 2'b00;
                end else if (w_stall_b) begin
                    w_issue     = 2'b01;
                    w_latch_b   = 1'b1;
                    w_state_nxt = HOLD_B;
                end else begin
                    w_issue   = {w_b_valid, w_a_valid};
                    w_d_ready = 1'b1;
                end
            end
            HOLD_B: begin
                if (!w_stall_a) begin
                    w_issue     = 2'b01;
                    w_d_ready   = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
        if (flush) begin
            w_state_nxt = RUN;
            w_issue     = 2'b00;
            w_latch_b   = 1'b0;
        end
    end

    assign d_ready    = resetn && w_d_ready;
    assign hold_valid = (r_state == HOLD_B);
    assign hold_ra1   = r_hold_ra1;
    assign hold_ra2   = r_hold_ra2;
    assign hold_dst   = r_hold_dst;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= RUN;
            e_valid <= 2'b00;
            e_pc    <= '0;
            e_dst   <= '0;
            e_opa   <= '0;
            e_opb   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            e_valid  <= w_issue;
            e_pc[0]  <= w_issue[0] ? w_a_pc  : '0;
            e_dst[0] <= w_issue[0] ? w_a_dst : '0;
            e_opa[0] <= w_issue[0] ? w_opa_a : '0;
            e_opb[0] <= w_issue[0] ? w_opb_a : '0;
            e_pc[1]  <= w_issue[1] ? d_pc[1]  : '0;
            e_dst[1] <= w_issue[1] ? d_dst[1] : '0;
            e_opa[1] <= w_issue[1] ? w_opa_b  : '0;
            e_opb[1] <= w_issue[1] ? w_opb_b  : '0;
        end
    end

    // NOTE: the hold payload needs no reset; it is only observed while hold_valid is set.
    always_ff @(posedge clk) begin
        if (w_latch_b) begin
            r_hold_pc  <= d_pc[1];
            r_hold_ra1 <= d_ra1[1];
            r_hold_ra2 <= d_ra2[1];
            r_hold_dst <= d_dst[1];
            r_hold_rd1 <= d_rd1[1];
            r_hold_rd2 <= d_rd2[1];
        end
    end

`ifdef ISSUE_STATS_EN
    logic [CNT_W-1:0] r_stat_bubble, r_stat_split;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stat_bubble <= '0;
            r_stat_split  <= '0;
        end else begin
            if (!flush && (w_issue == 2'b00) && (r_stat_bubble != '1))
                r_stat_bubble <= r_stat_bubble + CNT_W'(1);
            if (w_latch_b && (r_stat_split != '1))
                r_stat_split <= r_stat_split + CNT_W'(1);
        end
    end

    assign stat_bubble = r_stat_bubble;
    assign stat_split  = r_stat_split;
`endif

endmodule

// File: tb/tb_issue_hold_reg.sv
// Self-checking bench for issue_hold_reg: directed scenarios then random traffic,
// compared against an in-order candidate-list model of the issue rules.
module tb_issue_hold_reg;
    localparam int DW = 64;
    localparam int RW = 5;
    localparam int CW = 32;

    logic                 clk = 1'b0;
    logic                 resetn, flush;
    logic [1:0]           d_valid;
    logic [1:0][DW-1:0]   d_pc, d_rd1, d_rd2;
    logic [1:0][RW-1:0]   d_ra1, d_ra2, d_dst;
    logic [1:0]           sel_stall;
    logic [1:0][1:0]      sel_a, sel_b;
    logic [DW-1:0]        aluoutE, aluoutM, memdataM;
    logic                 d_ready, hold_valid;
    logic [RW-1:0]        hold_ra1, hold_ra2, hold_dst;
    logic [1:0]           e_valid;
    logic [1:0][DW-1:0]   e_pc, e_opa, e_opb;
    logic [1:0][RW-1:0]   e_dst;
`ifdef ISSUE_STATS_EN
    logic [CW-1:0]        stat_bubble, stat_split;
`endif

    issue_hold_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .d_valid(d_valid),
        .d_pc(d_pc), .d_ra1(d_ra1), .d_ra2(d_ra2), .d_dst(d_dst),
        .d_rd1(d_rd1), .d_rd2(d_rd2), .sel_stall(sel_stall),
        .sel_a(sel_a), .sel_b(sel_b),
        .aluoutE(aluoutE), .aluoutM(aluoutM), .memdataM(memdataM),
        .d_ready(d_ready), .hold_valid(hold_valid),
        .hold_ra1(hold_ra1), .hold_ra2(hold_ra2), .hold_dst(hold_dst),
        .e_valid(e_valid), .e_pc(e_pc), .e_dst(e_dst), .e_opa(e_opa), .e_opb(e_opb)
`ifdef ISSUE_STATS_EN
        , .stat_bubble(stat_bubble), .stat_split(stat_split)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pc, rd1, rd2;
        logic [RW-1:0] ra1, ra2, dst;
    } insn_t;

    int            n_chk = 0;
    int            n_err = 0;
    bit            m_held;
    insn_t         m_hold;
    logic [1:0]    x_valid;
    logic [DW-1:0] x_pc[2], x_opa[2], x_opb[2];
    logic [RW-1:0] x_dst[2];
    int unsigned   x_bub, x_split;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [RW-1:0] ra,
                                           input logic [DW-1:0] rd);
        logic [DW-1:0] src[4];
        src[0] = rd; src[1] = aluoutE; src[2] = aluoutM; src[3] = memdataM;
        return (ra == 0) ? rd : src[sel];
    endfunction

    function automatic insn_t d_insn(input int k);
        insn_t t;
        t.pc = d_pc[k]; t.rd1 = d_rd1[k]; t.rd2 = d_rd2[k];
        t.ra1 = d_ra1[k]; t.ra2 = d_ra2[k]; t.dst = d_dst[k];
        return t;
    endfunction

    // Model: the oldest pending instructions form a candidate list; position k uses
    // slot k controls. The longest unstalled prefix issues; a stranded second entry is held.
    task automatic tick();
        insn_t c[$];
        int    n;
        bit    exp_ready;
        if (m_held) c.push_back(m_hold);
        else begin
            if (d_valid[0]) c.push_back(d_insn(0));
            if (d_valid[0] && d_valid[1]) c.push_back(d_insn(1));
        end
        n = 0;
        while (n < c.size() && !sel_stall[n]) n++;
        exp_ready = resetn && (n == c.size());
        #1;
        if (!flush) check("d_ready", {63'd0, d_ready}, {63'd0, exp_ready});
        for (int k = 0; k < 2; k++) begin
            x_pc[k] = '0; x_dst[k] = '0; x_opa[k] = '0; x_opb[k] = '0;
        end
        if (!resetn) begin
            m_held = 0; x_valid = 2'b00; x_bub = 0; x_split = 0;
        end else if (flush) begin
            m_held = 0; x_valid = 2'b00;
        end else begin
            x_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
            for (int k = 0; k < n; k++) begin
                x_pc[k]  = c[k].pc;
                x_dst[k] = c[k].dst;
                x_opa[k] = pick(sel_a[k], c[k].ra1, c[k].rd1);
                x_opb[k] = pick(sel_b[k], c[k].ra2, c[k].rd2);
            end
            if (n == 0) x_bub++;
            if (m_held && n == 1) m_held = 0;
            else if (!m_held && n == 1 && c.size() == 2) begin
                m_held = 1; m_hold = c[1]; x_split++;
            end
        end
        @(posedge clk);
        #1;
        check("e_valid", {62'd0, e_valid}, {62'd0, x_valid});
        for (int k = 0; k < 2; k++) begin
            check($sformatf("e_pc[%0d]", k),  e_pc[k],  x_pc[k]);
            check($sformatf("e_dst[%0d]", k), {59'd0, e_dst[k]}, {59'd0, x_dst[k]});
            check($sformatf("e_opa[%0d]", k), e_opa[k], x_opa[k]);
            check($sformatf("e_opb[%0d]", k), e_opb[k], x_opb[k]);
        end
        check("hold_valid", {63'd0, hold_valid}, {63'd0, m_held});
        if (m_held) begin
            check("hold_ra1", {59'd0, hold_ra1}, {59'd0, m_hold.ra1});
            check("hold_ra2", {59'd0, hold_ra2}, {59'd0, m_hold.ra2});
            check("hold_dst", {59'd0, hold_dst}, {59'd0, m_hold.dst});
        end
`ifdef ISSUE_STATS_EN
        check("stat_bubble", {32'd0, stat_bubble}, {32'd0, x_bub});
        check("stat_split",  {32'd0, stat_split},  {32'd0, x_split});
`endif
    endtask

    task automatic quiet();
        flush = 0; d_valid = 2'b00; sel_stall = 2'b00; sel_a = '0; sel_b = '0;
        d_pc = '0; d_rd1 = '0; d_rd2 = '0; d_dst = '0;
        d_ra1 = {5'd2, 5'd1}; d_ra2 = {5'd4, 5'd3};
        aluoutE = '0; aluoutM = '0; memdataM = '0;
    endtask

    task automatic pair(input logic [DW-1:0] pca, input logic [DW-1:0] pcb);
        d_valid = 2'b11; d_pc[0] = pca; d_pc[1] = pcb;
        d_dst = {5'd11, 5'd10};
        d_rd1 = {64'h21, 64'h11}; d_rd2 = {64'h22, 64'h12};
    endtask

    task automatic randomize_inputs();
        int v;
        v = $urandom_range(0, 2);
        d_valid   = (v == 0) ? 2'b00 : (v == 1) ? 2'b01 : 2'b11;
        flush     = ($urandom_range(0, 31) == 0);
        resetn    = ($urandom_range(0, 199) != 0);
        sel_stall = 2'($urandom_range(0, 3));
        for (int k = 0; k < 2; k++) begin
            d_pc[k]  = {$urandom, $urandom};
            d_rd1[k] = {$urandom, $urandom};
            d_rd2[k] = {$urandom, $urandom};
            d_ra1[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            d_ra2[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            d_dst[k] = 5'($urandom);
            sel_a[k] = 2'($urandom);
            sel_b[k] = 2'($urandom);
        end
        aluoutE  = {$urandom, $urandom};
        aluoutM  = {$urandom, $urandom};
        memdataM = {$urandom, $urandom};
    endtask

    initial begin
        m_held = 0; x_bub = 0; x_split = 0; x_valid = 2'b00;
        quiet();
        resetn = 0;
        @(negedge clk); tick();
        @(negedge clk); tick();

        // Basic dual issue with register-file operands.
        @(negedge clk); resetn = 1; pair(64'h1000, 64'h1004); d_rd1[0] = 64'd5; tick();
        check("dir_valid_11", {62'd0, e_valid}, 64'd3);
        check("dir_opa_rd", e_opa[0], 64'd5);

        // Forwarding from ALUOUTE on slot A and MEMDATA on slot B.
        @(negedge clk); pair(64'h1008, 64'h100c);
        sel_a[0] = 2'd1; aluoutE = 64'h1234; sel_b[1] = 2'd3; memdataM = 64'hBEEF; tick();
        check("dir_fwd_e", e_opa[0], 64'h1234);
        check("dir_fwd_mem", e_opb[1], 64'hBEEF);

        // Source register 0 ignores the forwarding select.
        @(negedge clk); quiet(); pair(64'h1010, 64'h1014);
        d_ra1[0] = 5'd0; sel_a[0] = 2'd2; aluoutM = 64'hDEAD; tick();
        check("dir_r0_rd", e_opa[0], 64'h11);

        // Slot A stall for two cycles, then the pair issues.
        @(negedge clk); quiet(); pair(64'h2000, 64'h2004); sel_stall = 2'b01; tick();
        @(negedge clk); tick();
        check("dir_bubble", {62'd0, e_valid}, 64'd0);
        @(negedge clk); sel_stall = 2'b00; tick();
        check("dir_after_stall", {62'd0, e_valid}, 64'd3);

        // Split issue, then the held slot B issues alone.
        @(negedge clk); pair(64'h3000, 64'h80000004); sel_stall = 2'b10; tick();
        check("dir_split_hold", {63'd0, hold_valid}, 64'd1);
        @(negedge clk); sel_stall = 2'b00; tick();
        check("dir_hold_pc", e_pc[0], 64'h80000004);

        // Flush while holding.
        @(negedge clk); pair(64'h4000, 64'h4004); sel_stall = 2'b10; tick();
        @(negedge clk); flush = 1; sel_stall = 2'b00; tick();
        check("dir_flush_hold", {63'd0, hold_valid}, 64'd0);
        @(negedge clk); flush = 0; d_valid = 2'b00; tick();

        // Reset while holding.
        @(negedge clk); pair(64'h5000, 64'h5004); sel_stall = 2'b10; tick();
        @(negedge clk); resetn = 0; sel_stall = 2'b00; tick();
        check("dir_reset_pc", e_pc[0], 64'd0);

`ifdef ISSUE_STATS_EN
        @(negedge clk); resetn = 1; pair(64'h6000, 64'h6004); sel_stall = 2'b01;
        for (int i = 0; i < 3; i++) begin tick(); @(negedge clk); end
        sel_stall = 2'b10; tick();
        check("dir_stat_bubble", {32'd0, stat_bubble}, 64'd3);
        check("dir_stat_split", {32'd0, stat_split}, 64'd1);
`endif

        @(negedge clk); resetn = 1; quiet(); tick();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            randomize_inputs();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
